// File: rtl/exdata_scan_ctrl.sv
// Run controller and readout sequencer for a bank of exdata counters: live window, settle, snapshot, serial readout.
// Optional livetime channel (extra word at index N_CH) enabled by defining EXDATA_SCAN_LIVETIME_EN.

module exdata_scan_lane #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         cap,
  input  logic [W-1:0] din,
  output logic [W-1:0] q
);
  always_ff @(posedge clk) begin
    if (!rst_n)   q <= '0;
    else if (cap) q <= din;
  end
endmodule

module exdata_scan_ctrl #(
  parameter int N_CH       = 8,
  parameter int CNT_W      = 32,
  parameter int ARM_CYC    = 2,
  parameter int SETTLE_CYC = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic                       stop,
  input  logic [N_CH*CNT_W-1:0]      cnt_bus,
  output logic                       live,
  output logic                       rd_valid,
  input  logic                       rd_ready,
  output logic [$clog2(N_CH+1)-1:0]  rd_ch,
  output logic [CNT_W-1:0]           rd_data,
  output logic                       busy,
  output logic                       done
);
  localparam int CH_W = $clog2(N_CH+1);
`ifdef EXDATA_SCAN_LIVETIME_EN
  localparam int N_WORDS = N_CH + 1;
`else
  localparam int N_WORDS = N_CH;
`endif
  localparam logic [CH_W-1:0] LAST_CH = CH_W'(N_WORDS - 1);
  localparam int TMR_MAX = (ARM_CYC > SETTLE_CYC) ? ARM_CYC : SETTLE_CYC;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);

  typedef enum logic [2:0] {IDLE, ARM, LIVE, SETTLE, SNAP, SCAN, DONE} state_t;

  state_t                         state;
  logic [TMR_W-1:0]               tmr;
  logic                           stop_pend;
  logic                           snap_en;
  logic [N_WORDS-1:0][CNT_W-1:0]  snap_d, snap_q;
  logic [CH_W-1:0]                nxt_ch;
  logic [CNT_W-1:0]               nxt_word;

  assign snap_en = (state == SNAP);

`ifdef EXDATA_SCAN_LIVETIME_EN
  logic [CNT_W-1:0] lt_cnt;

  // Held at zero through ARM so it starts from 0 on LIVE entry; saturates instead of wrapping.
  always_ff @(posedge clk) begin
    if (!rst_n)                              lt_cnt <= '0;
    else if (state == ARM)                   lt_cnt <= '0;
    else if (state == LIVE && lt_cnt != '1)  lt_cnt <= lt_cnt + CNT_W'(1);
  end

  assign snap_d = {lt_cnt, cnt_bus};
`else
  assign snap_d = cnt_bus;
`endif

  for (genvar g = 0; g < N_WORDS; g++) begin : g_lane
    exdata_scan_lane #(.W(CNT_W)) u_lane (
      .clk   (clk),
      .rst_n (rst_n),
      .cap   (snap_en),
      .din   (snap_d[g]),
      .q     (snap_q[g])
    );
  end

  assign nxt_ch = rd_ch + CH_W'(1);

  always_comb begin
    nxt_word = '0;
    for (int i = 0; i < N_WORDS; i++)
      if (nxt_ch == CH_W'(i)) nxt_word = snap_q[i];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      live      <= 1'b0;
      rd_valid  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      rd_ch     <= '0;
      rd_data   <= '0;
      tmr       <= '0;
      stop_pend <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          state     <= ARM;
          busy      <= 1'b1;
          tmr       <= '0;
          stop_pend <= 1'b0;
        end
        ARM: begin
          if (stop) stop_pend <= 1'b1;
          if (tmr == TMR_W'(ARM_CYC)) begin
            state <= LIVE;
            live  <= 1'b1;
            tmr   <= '0;
          end else begin
            tmr <= tmr + TMR_W'(1);
          end
        end
        // An early stop from ARM still yields one live cycle so the counters see a full window edge pair.
        LIVE: if (stop || stop_pend) begin
          state     <= SETTLE;
          live      <= 1'b0;
          stop_pend <= 1'b0;
        end
        SETTLE: begin
          if (tmr == TMR_W'(SETTLE_CYC - 1)) begin
            state <= SNAP;
            tmr   <= '0;
          end else begin
            tmr <= tmr + TMR_W'(1);
          end
        end
        SNAP: begin
          state    <= SCAN;
          rd_valid <= 1'b1;
          rd_ch    <= '0;
          rd_data  <= cnt_bus[CNT_W-1:0];
        end
        SCAN: if (rd_ready) begin
          if (rd_ch == LAST_CH) begin
            state    <= DONE;
            rd_valid <= 1'b0;
            done     <= 1'b1;
          end else begin
            rd_ch   <= nxt_ch;
            rd_data <= nxt_word;
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_exdata_scan_ctrl.sv
// Scoreboard bench for exdata_scan_ctrl: golden counters feed cnt_bus, expected words queued per run.
// A narrow second instance exercises livetime saturation when EXDATA_SCAN_LIVETIME_EN is defined.
module tb_exdata_scan_ctrl;
  localparam int N_CH = 4, CNT_W = 32, ARM_CYC = 2, SETTLE_CYC = 2;
  localparam int CH_W = $clog2(N_CH+1);
`ifdef EXDATA_SCAN_LIVETIME_EN
  localparam int N_WORDS = N_CH + 1;
`else
  localparam int N_WORDS = N_CH;
`endif

  typedef struct { int ch; logic [CNT_W-1:0] data; int cyc; } word_t;

  logic clk, rst_n, start, stop, rd_ready;
  logic [N_CH*CNT_W-1:0] cnt_bus;
  logic live, rd_valid, busy, done;
  logic [CH_W-1:0] rd_ch;
  logic [CNT_W-1:0] rd_data;

  int checks = 0, failures = 0, cyc = 0, live_cnt = 0;
  word_t exp_q[$], obs_q[$];
  int tgt[N_CH];
  logic [CNT_W-1:0] cnt [N_CH];
  logic live_q;

  exdata_scan_ctrl #(.N_CH(N_CH), .CNT_W(CNT_W), .ARM_CYC(ARM_CYC), .SETTLE_CYC(SETTLE_CYC)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .cnt_bus(cnt_bus),
    .live(live), .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_ch(rd_ch),
    .rd_data(rd_data), .busy(busy), .done(done));

`ifdef EXDATA_SCAN_LIVETIME_EN
  logic live2, rd_valid2, busy2, done2;
  logic [0:0] rd_ch2;
  logic [3:0] rd_data2;
  word_t obs2_q[$];
  exdata_scan_ctrl #(.N_CH(1), .CNT_W(4), .ARM_CYC(ARM_CYC), .SETTLE_CYC(SETTLE_CYC)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .cnt_bus(4'd0),
    .live(live2), .rd_valid(rd_valid2), .rd_ready(rd_ready), .rd_ch(rd_ch2),
    .rd_data(rd_data2), .busy(busy2), .done(done2));
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Golden counters: clear on live rising edge, count one pulse per live cycle until target reached.
  always @(posedge clk) begin
    live_q <= live;
    for (int k = 0; k < N_CH; k++) begin
      if (live === 1'b1) begin
        logic [CNT_W-1:0] b;
        b = (live_q !== 1'b1) ? '0 : cnt[k];
        cnt[k] <= (int'(b) < tgt[k]) ? b + CNT_W'(1) : b;
      end
    end
  end

  always_comb begin
    cnt_bus = '0;
    for (int k = 0; k < N_CH; k++) cnt_bus[k*CNT_W +: CNT_W] = cnt[k];
  end

  task automatic edge1(); @(posedge clk); #1; endtask

  task automatic tick();
    word_t w;
    @(negedge clk);
    cyc++;
    if (live === 1'b1) live_cnt++;
    if (rst_n && rd_valid === 1'b1 && rd_ready) begin
      w.ch = int'(rd_ch); w.data = rd_data; w.cyc = cyc; obs_q.push_back(w);
    end
`ifdef EXDATA_SCAN_LIVETIME_EN
    if (rst_n && rd_valid2 === 1'b1 && rd_ready) begin
      w.ch = int'(rd_ch2); w.data = CNT_W'(rd_data2); w.cyc = cyc; obs2_q.push_back(w);
    end
`endif
  endtask

  task automatic push_exp(input int live_len);
    word_t w;
    for (int k = 0; k < N_CH; k++) begin
      w.ch = k; w.data = CNT_W'((tgt[k] < live_len) ? tgt[k] : live_len); w.cyc = 0;
      exp_q.push_back(w);
    end
`ifdef EXDATA_SCAN_LIVETIME_EN
    w.ch = N_CH; w.data = CNT_W'(live_len); exp_q.push_back(w);
`endif
  endtask

  task automatic start_run(input bit with_stop, input bit stop_in_arm, output int dly);
    edge1(); start = 1'b1; stop = with_stop;
    edge1(); start = 1'b0; stop = stop_in_arm;
    edge1(); stop = 1'b0;
    dly = -1;
    for (int k = 2; k < 20; k++) begin
      tick();
      if (live === 1'b1) begin dly = k - 1; break; end
      edge1();
    end
  endtask

  task automatic end_live(input int live_len, input bit start_mid);
    for (int i = 1; i < live_len; i++) begin
      edge1(); start = start_mid && (i == 2); stop = (i == live_len - 1); tick();
    end
    edge1(); start = 1'b0; stop = 1'b0; tick();
  endtask

  task automatic wait_done(input bit start_in_scan, output int done_cyc, output int done_len,
                           output logic busy_after, output bit to);
    done_cyc = -1; done_len = 0; to = 1'b1; busy_after = 1'bx;
    for (int i = 0; i < 300; i++) begin
      edge1(); start = start_in_scan && (rd_valid === 1'b1) && (obs_q.size() == 1);
      tick();
      if (done === 1'b1) begin
        done_len++;
        if (done_cyc < 0) done_cyc = cyc;
      end else if (done_cyc >= 0) begin
        busy_after = busy; to = 1'b0; break;
      end
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; stop = 1'b0; rd_ready = 1'b1;
    edge1(); edge1(); tick();
    checks++; if (live !== 1'b0) begin failures++; $display("FAIL reset_live got=%b exp=0", live); end
    checks++; if (rd_valid !== 1'b0) begin failures++; $display("FAIL reset_rd_valid got=%b exp=0", rd_valid); end
    checks++; if ({busy, done} !== 2'b00) begin failures++; $display("FAIL reset_busy_done got=%b exp=00", {busy, done}); end
    checks++; if (rd_ch !== '0 || rd_data !== '0) begin
      failures++; $display("FAIL reset_rd got ch=%0d data=%0d exp=0/0", rd_ch, rd_data); end
    edge1(); rst_n = 1'b1; tick();
  endtask

  task automatic test_basic();
    int dly, dc, dl, base; bit to; logic ba; word_t e, o; int first_c, last_c;
    tgt = '{5, 0, 7, 10}; exp_q.delete(); obs_q.delete(); base = live_cnt;
    push_exp(10);
    start_run(1'b0, 1'b0, dly);
    checks++; if (dly != ARM_CYC + 1) begin failures++; $display("FAIL basic_live_rise got=%0d exp=%0d", dly, ARM_CYC + 1); end
    end_live(10, 1'b0);
    wait_done(1'b0, dc, dl, ba, to);
    checks++; if (to) begin failures++; $display("FAIL basic_done_timeout got=timeout exp=done"); end
    checks++; if (live_cnt - base != 10) begin failures++; $display("FAIL basic_live_len got=%0d exp=10", live_cnt - base); end
    checks++; if (obs_q.size() != N_WORDS) begin failures++; $display("FAIL basic_count got=%0d exp=%0d", obs_q.size(), N_WORDS); end
    if (obs_q.size() == N_WORDS) begin
      first_c = obs_q[0].cyc; last_c = obs_q[N_WORDS-1].cyc;
      checks++; if (last_c - first_c != N_WORDS - 1) begin
        failures++; $display("FAIL basic_back_to_back got=%0d exp=%0d", last_c - first_c, N_WORDS - 1); end
      checks++; if (dc != last_c + 1) begin failures++; $display("FAIL basic_done_cycle got=%0d exp=%0d", dc, last_c + 1); end
    end
    checks++; if (dl != 1) begin failures++; $display("FAIL basic_done_len got=%0d exp=1", dl); end
    checks++; if (ba !== 1'b0) begin failures++; $display("FAIL basic_busy_after got=%b exp=0", ba); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o.ch !== e.ch || o.data !== e.data) begin
        failures++; $display("FAIL basic_word got=(%0d,%0d) exp=(%0d,%0d)", o.ch, o.data, e.ch, e.data); end
    end
  endtask

  task automatic test_backpressure();
    int dly, dc, dl; bit to, found; logic ba; word_t e, o;
    logic [CH_W-1:0] hch; logic [CNT_W-1:0] hdata;
    tgt = '{3, 9, 1, 4}; exp_q.delete(); obs_q.delete();
    push_exp(8);
    start_run(1'b0, 1'b0, dly);
    end_live(8, 1'b0);
    found = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (rd_valid === 1'b1 && rd_ch == 0) begin found = 1'b1; break; end
      edge1(); tick();
    end
    checks++; if (!found) begin failures++; $display("FAIL bp_ch0_timeout got=none exp=ch0"); end
    edge1(); rd_ready = 1'b0; tick();
    hch = rd_ch; hdata = rd_data;
    checks++; if (hch !== CH_W'(1) || hdata !== CNT_W'(8)) begin
      failures++; $display("FAIL bp_stall_word got=(%0d,%0d) exp=(1,8)", hch, hdata); end
    for (int j = 0; j < 3; j++) begin
      if (j > 0) begin edge1(); tick(); end
      checks++; if (rd_valid !== 1'b1 || rd_ch !== hch || rd_data !== hdata) begin
        failures++; $display("FAIL bp_hold got=(%b,%0d,%0d) exp=(1,%0d,%0d)", rd_valid, rd_ch, rd_data, hch, hdata); end
    end
    edge1(); rd_ready = 1'b1; tick();
    wait_done(1'b0, dc, dl, ba, to);
    checks++; if (to) begin failures++; $display("FAIL bp_done_timeout got=timeout exp=done"); end
    checks++; if (obs_q.size() != N_WORDS) begin failures++; $display("FAIL bp_count got=%0d exp=%0d", obs_q.size(), N_WORDS); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o.ch !== e.ch || o.data !== e.data) begin
        failures++; $display("FAIL bp_word got=(%0d,%0d) exp=(%0d,%0d)", o.ch, o.data, e.ch, e.data); end
    end
  endtask

  task automatic test_early_stop();
    int dly, dc, dl, base; bit to; logic ba; word_t e, o;
    tgt = '{5, 0, 7, 10}; exp_q.delete(); obs_q.delete(); base = live_cnt;
    push_exp(1);
    start_run(1'b0, 1'b1, dly);
    wait_done(1'b0, dc, dl, ba, to);
    checks++; if (to) begin failures++; $display("FAIL early_done_timeout got=timeout exp=done"); end
    checks++; if (live_cnt - base != 1) begin failures++; $display("FAIL early_live_len got=%0d exp=1", live_cnt - base); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o.ch !== e.ch || o.data !== e.data) begin
        failures++; $display("FAIL early_word got=(%0d,%0d) exp=(%0d,%0d)", o.ch, o.data, e.ch, e.data); end
    end
    // start and stop together from IDLE: stop must be discarded
    exp_q.delete(); obs_q.delete(); base = live_cnt;
    push_exp(6);
    start_run(1'b1, 1'b0, dly);
    checks++; if (dly != ARM_CYC + 1) begin failures++; $display("FAIL startstop_live_rise got=%0d exp=%0d", dly, ARM_CYC + 1); end
    end_live(6, 1'b0);
    wait_done(1'b0, dc, dl, ba, to);
    checks++; if (live_cnt - base != 6) begin failures++; $display("FAIL startstop_live_len got=%0d exp=6", live_cnt - base); end
    checks++; if (obs_q.size() != N_WORDS) begin failures++; $display("FAIL startstop_count got=%0d exp=%0d", obs_q.size(), N_WORDS); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o.ch !== e.ch || o.data !== e.data) begin
        failures++; $display("FAIL startstop_word got=(%0d,%0d) exp=(%0d,%0d)", o.ch, o.data, e.ch, e.data); end
    end
  endtask

  task automatic test_ignored();
    int dly, dc, dl, base; bit to; logic ba; word_t e, o;
    edge1(); stop = 1'b1; edge1(); stop = 1'b0; tick(); edge1(); tick();
    checks++; if (busy !== 1'b0 || live !== 1'b0) begin
      failures++; $display("FAIL idle_stop got busy=%b live=%b exp=0/0", busy, live); end
    tgt = '{2, 4, 6, 8}; exp_q.delete(); obs_q.delete(); base = live_cnt;
    push_exp(10);
    start_run(1'b0, 1'b0, dly);
    end_live(10, 1'b1);
    wait_done(1'b1, dc, dl, ba, to);
    checks++; if (live_cnt - base != 10) begin failures++; $display("FAIL ign_live_len got=%0d exp=10", live_cnt - base); end
    checks++; if (dl != 1 || ba !== 1'b0) begin failures++; $display("FAIL ign_done got len=%0d busy=%b exp=1/0", dl, ba); end
    checks++; if (obs_q.size() != N_WORDS) begin failures++; $display("FAIL ign_count got=%0d exp=%0d", obs_q.size(), N_WORDS); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o.ch !== e.ch || o.data !== e.data) begin
        failures++; $display("FAIL ign_word got=(%0d,%0d) exp=(%0d,%0d)", o.ch, o.data, e.ch, e.data); end
    end
    edge1(); tick(); edge1(); tick();
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL ign_no_queue got busy=%b exp=0", busy); end
  endtask

  task automatic test_reset_mid_scan();
    int dly, dc, dl; bit to, found; logic ba; word_t e, o;
    tgt = '{1, 2, 3, 4}; exp_q.delete(); obs_q.delete();
    push_exp(5);
    start_run(1'b0, 1'b0, dly);
    end_live(5, 1'b0);
    found = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (rd_valid === 1'b1 && rd_ch == 2) begin found = 1'b1; break; end
      edge1(); tick();
    end
    checks++; if (!found) begin failures++; $display("FAIL rst_ch2_timeout got=none exp=ch2"); end
    rst_n = 1'b0;
    if (obs_q.size() > 0) void'(obs_q.pop_back());
    checks++; if (obs_q.size() != 2) begin failures++; $display("FAIL rst_pre_count got=%0d exp=2", obs_q.size()); end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o.ch !== e.ch || o.data !== e.data) begin
        failures++; $display("FAIL rst_pre_word got=(%0d,%0d) exp=(%0d,%0d)", o.ch, o.data, e.ch, e.data); end
    end
    exp_q.delete();
    edge1(); rst_n = 1'b1; tick();
    checks++; if ({rd_valid, live, busy, done} !== 4'b0000) begin
      failures++; $display("FAIL rst_mid_outputs got=%b exp=0000", {rd_valid, live, busy, done}); end
    tgt = '{4, 3, 2, 1}; obs_q.delete();
    push_exp(7);
    start_run(1'b0, 1'b0, dly);
    end_live(7, 1'b0);
    wait_done(1'b0, dc, dl, ba, to);
    checks++; if (to || obs_q.size() != N_WORDS) begin
      failures++; $display("FAIL rst_rerun_count got=%0d exp=%0d", obs_q.size(), N_WORDS); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o.ch !== e.ch || o.data !== e.data) begin
        failures++; $display("FAIL rst_rerun_word got=(%0d,%0d) exp=(%0d,%0d)", o.ch, o.data, e.ch, e.data); end
    end
  endtask

`ifdef EXDATA_SCAN_LIVETIME_EN
  task automatic test_livetime_sat();
    int dly, dc, dl; bit to; logic ba; word_t e, o;
    tgt = '{1, 1, 1, 1}; exp_q.delete(); obs_q.delete(); obs2_q.delete();
    push_exp(20);
    start_run(1'b0, 1'b0, dly);
    end_live(20, 1'b0);
    wait_done(1'b0, dc, dl, ba, to);
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o.ch !== e.ch || o.data !== e.data) begin
        failures++; $display("FAIL lt_word got=(%0d,%0d) exp=(%0d,%0d)", o.ch, o.data, e.ch, e.data); end
    end
    checks++; if (obs2_q.size() != 2) begin failures++; $display("FAIL lt_sat_count got=%0d exp=2", obs2_q.size()); end
    else begin
      checks++; if (obs2_q[1].ch != 1 || obs2_q[1].data !== CNT_W'(15)) begin
        failures++; $display("FAIL lt_sat_word got=(%0d,%0d) exp=(1,15)", obs2_q[1].ch, obs2_q[1].data); end
    end
  endtask
`endif

  initial begin
    for (int k = 0; k < N_CH; k++) begin tgt[k] = 0; cnt[k] = '0; end
    live_q = 1'b0;
    test_reset();
    test_basic();
    test_backpressure();
    test_early_stop();
    test_ignored();
    test_reset_mid_scan();
`ifdef EXDATA_SCAN_LIVETIME_EN
    test_livetime_sat();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
